// File: rtl/spm_pkg.sv
// Shared types, defaults and the run-length helper for the spm sequencing controller.
package spm_pkg;

    localparam int unsigned SPM_WIDTH_DEF = 32;
    localparam int unsigned SPM_LAT_DEF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spm_state_e;

    // Number of RUN cycles: 2*WIDTH serial product bits plus the multiplier latency.
    function automatic int unsigned spm_run_len(input int unsigned width, input int unsigned lat);
        return 2 * width + lat;
    endfunction

endpackage

// File: rtl/spm_ctrl_if.sv
// Operand/product valid-ready bus between the operand source and spm_ctrl.
interface spm_ctrl_if
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = SPM_WIDTH_DEF
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );

endinterface

// File: rtl/spm_serdes.sv
// Y parallel-in/serial-out and P serial-in/parallel-out registers for the spm datapath.
module spm_serdes
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = SPM_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [2*WIDTH-1:0]   y_word,
    input  logic                 shift_en,
    input  logic                 capture_en,
    input  logic                 p_bit,
    output logic                 y_bit,
    output logic [2*WIDTH-1:0]   p_word
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] y_q;
    logic [PW-1:0] p_q;

    // Y holds the operand plus its extension bits; zeros shift in so spm_y idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else if (load) begin
            y_q <= y_word;
        end else if (shift_en) begin
            y_q <= {1'b0, y_q[PW-1:1]};
        end
    end

    // Product bits arrive LSB first, so each one enters at the MSB and ripples down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else if (load) begin
            p_q <= '0;
        end else if (capture_en) begin
            p_q <= {p_bit, p_q[PW-1:1]};
        end
    end

    assign y_bit  = y_q[0];
    assign p_word = p_q;

endmodule

// File: rtl/spm_ctrl.sv
// Sequencing controller for the serial-parallel multiplier: accepts X/Y, streams Y, collects P.
// Optional SPM_CTRL_SIGNED_EN sign-extends Y for a two's-complement product.
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH   = SPM_WIDTH_DEF,
    parameter int unsigned SPM_LAT = SPM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    spm_ctrl_if.slave         bus,
    output logic              busy,
    output logic              spm_rst,
    output logic [WIDTH-1:0]  spm_x,
    output logic              spm_y,
    input  logic              spm_p
);

    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned RUN_LEN = spm_run_len(WIDTH, SPM_LAT);
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1);

    spm_state_e       state_q;
    spm_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             shift_en;
    logic             capture_en;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_ext;
    logic [PW-1:0]    p_word;

    // Next-state logic; accepts only from IDLE, so DONE never bypasses into a new run.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(RUN_LEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run-cycle counter: value c during RUN cycle c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Status outputs registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            spm_rst     <= 1'b1;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy        <= (state_d != ST_IDLE);
            spm_rst     <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spm_x <= '0;
        end else if (accept) begin
            spm_x <= bus.in_x;
        end
    end

`ifdef SPM_CTRL_SIGNED_EN
    assign y_ext = {WIDTH{bus.in_y[WIDTH-1]}};
`else
    assign y_ext = '0;
`endif

    assign shift_en   = (state_q == ST_RUN);
    // The first SPM_LAT cycles only fill the multiplier pipeline.
    assign capture_en = (state_q == ST_RUN) && (cnt_q >= CNT_W'(SPM_LAT));

    spm_serdes #(
        .WIDTH (WIDTH)
    ) u_serdes (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .y_word     ({y_ext, bus.in_y}),
        .shift_en   (shift_en),
        .capture_en (capture_en),
        .p_bit      (spm_p),
        .y_bit      (spm_y),
        .p_word     (p_word)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_word;

endmodule

// File: tb/tb_spm_ctrl.sv
// Randomized bench for spm_ctrl with a behavioural spm multiplier and product reference model.
module tb_spm_ctrl;
    import spm_pkg::*;

    localparam int unsigned W   = SPM_WIDTH_DEF;
    localparam int unsigned LAT = SPM_LAT_DEF;
    localparam int          LATENCY = 2 * 32 + 1;
    localparam int          MIN_II  = LATENCY + 2;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        spm_rst;
    logic [31:0] spm_x;
    logic        spm_y;
    logic        spm_p;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    spm_ctrl_if #(.WIDTH(W)) bus ();

    spm_ctrl #(
        .WIDTH   (W),
        .SPM_LAT (LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .spm_rst (spm_rst),
        .spm_x   (spm_x),
        .spm_y   (spm_y),
        .spm_p   (spm_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] x_ext(input logic [31:0] x);
`ifdef SPM_CTRL_SIGNED_EN
        return {{32{x[31]}}, x};
`else
        return {32'd0, x};
`endif
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
`ifdef SPM_CTRL_SIGNED_EN
        return 64'(longint'($signed(x)) * longint'($signed(y)));
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction

    // Behavioural spm: bit k of X*Y is known once Y bits 0..k have arrived; registered, latency 1.
    logic [63:0] spm_acc;
    int          spm_k;
    always @(posedge clk) begin
        if (spm_rst) begin
            spm_acc = 64'd0;
            spm_k   = 0;
            spm_p  <= 1'b0;
        end else if (spm_k < 64) begin
            if (spm_y) spm_acc = spm_acc + (x_ext(spm_x) << spm_k);
            spm_p <= spm_acc[spm_k];
            spm_k  = spm_k + 1;
        end
    end

    // Event recorder: accept edges, out_valid rise edges, products taken at handshake.
    int          acc_cyc_q[$];
    int          rise_cyc_q[$];
    logic [63:0] hs_p_q[$];
    logic        ov_prev = 1'b0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_cyc_q.push_back(cyc);
            if (bus.out_valid && !ov_prev) rise_cyc_q.push_back(cyc - 1);
            if (bus.out_valid && bus.out_ready) hs_p_q.push_back(bus.out_p);
            ov_prev = bus.out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k;
        k = 0;
        while (acc_cyc_q.size() < n && k < 200) begin step(); k++; end
        if (acc_cyc_q.size() < n) check({tag, "_acc_timeout"}, 64'(acc_cyc_q.size()), 64'(n));
    endtask

    task automatic wait_rise(input int n, input string tag);
        int k;
        k = 0;
        while (rise_cyc_q.size() < n && k < 200) begin step(); k++; end
        if (rise_cyc_q.size() < n) check({tag, "_rise_timeout"}, 64'(rise_cyc_q.size()), 64'(n));
    endtask

    task automatic wait_hs(input int n, input string tag);
        int k;
        k = 0;
        while (hs_p_q.size() < n && k < 300) begin step(); k++; end
        if (hs_p_q.size() < n) check({tag, "_hs_timeout"}, 64'(hs_p_q.size()), 64'(n));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_p"},     bus.out_p,          64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
        check({tag, "_spm_rst"},   64'(spm_rst),       64'd1);
        check({tag, "_spm_x"},     64'(spm_x),         64'd0);
        check({tag, "_spm_y"},     64'(spm_y),         64'd0);
    endtask

    // One transaction with a random output stall; inputs are scrambled right after the accept.
    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input string tag);
        int          na;
        int          nr;
        int          nh;
        int          stall;
        logic [63:0] exp_p;
        exp_p = ref_prod(x, y);
        na = acc_cyc_q.size();
        nr = rise_cyc_q.size();
        nh = hs_p_q.size();
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        wait_acc(na + 1, tag);
        bus.in_valid = 1'b0;
        bus.in_x     = $urandom;
        bus.in_y     = $urandom;
        wait_rise(nr + 1, tag);
        check({tag, "_latency"}, 64'(rise_cyc_q[nr] - acc_cyc_q[na]), 64'(LATENCY));
        stall = $urandom_range(0, 4);
        repeat (stall) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            step();
            check({tag, "_stall_p"}, bus.out_p, exp_p);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_hs(nh + 1, tag);
        bus.out_ready = 1'b0;
        check({tag, "_p"}, hs_p_q[nh], exp_p);
    endtask

    initial begin
        int rel_cyc;
        int na;
        int nh;
        int nr;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'd4;
        bus.in_y      = 32'd1;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check_reset("rst");

        // Operands already presented during reset are taken on the first edge after release.
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_acc(1, "t1");
        check("t1_acc_cyc", 64'(acc_cyc_q[0]), 64'(rel_cyc + 1));
        bus.in_valid = 1'b0;
        check("t1_busy",     64'(busy),         64'd1);
        check("t1_in_ready", 64'(bus.in_ready), 64'd0);
        check("t1_spm_rst",  64'(spm_rst),      64'd0);
        check("t1_spm_x",    64'(spm_x),        64'd4);
        check("t1_spm_y0",   64'(spm_y),        64'd1);
        wait_rise(1, "t1");
        check("t1_latency", 64'(rise_cyc_q[0] - acc_cyc_q[0]), 64'(LATENCY));
        check("t1_out_p", bus.out_p, 64'h4);

        // Stalled DONE: product held, input side closed while in_valid toggles.
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            step();
            check("stall_out_p",     bus.out_p,          64'h4);
            check("stall_in_ready",  64'(bus.in_ready),  64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        check("stall_no_accept", 64'(acc_cyc_q.size()), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("rel_in_ready",  64'(bus.in_ready),  64'd1);
        check("rel_out_valid", 64'(bus.out_valid), 64'd0);
        check("rel_busy",      64'(busy),          64'd0);
        check("rel_hs_p",      hs_p_q[0],          64'h4);

        // Back-to-back with out_ready tied high and in_valid held.
        na = acc_cyc_q.size();
        nh = hs_p_q.size();
        bus.out_ready = 1'b1;
        bus.in_x      = 32'd4;
        bus.in_y      = 32'd1;
        bus.in_valid  = 1'b1;
        wait_acc(na + 1, "b2b");
        bus.in_x = 32'd3;
        bus.in_y = 32'd1;
        wait_acc(na + 2, "b2b");
        bus.in_valid = 1'b0;
        wait_hs(nh + 2, "b2b");
        bus.out_ready = 1'b0;
        check("b2b_gap", 64'(acc_cyc_q[na + 1] - acc_cyc_q[na]), 64'(MIN_II));
        check("b2b_p0",  hs_p_q[nh],     64'd4);
        check("b2b_p1",  hs_p_q[nh + 1], 64'd3);
        step();

`ifdef SPM_CTRL_SIGNED_EN
        run_one(32'hFFFF_FFFD, 32'd5, "neg3x5");
        check("neg3x5_const", hs_p_q[hs_p_q.size() - 1], 64'hFFFF_FFFF_FFFF_FFF1);
`else
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        check("max_const", hs_p_q[hs_p_q.size() - 1], 64'hFFFF_FFFE_0000_0001);
`endif
        run_one(32'd0, $urandom, "zero_x");
        run_one($urandom, 32'd0, "zero_y");
        run_one(32'h8000_0000, 32'h8000_0000, "msb");
        for (int i = 0; i < 8; i++) begin
            run_one($urandom, $urandom, "rand");
        end

        // Asynchronous abort at RUN cycle 30, then a fresh operation.
        nr = rise_cyc_q.size();
        na = acc_cyc_q.size();
        bus.in_x     = 32'd9;
        bus.in_y     = 32'd11;
        bus.in_valid = 1'b1;
        wait_acc(na + 1, "abort");
        bus.in_valid = 1'b0;
        repeat (30) step();
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_one(32'd7, 32'd6, "post_abort");
        check("post_abort_const", hs_p_q[hs_p_q.size() - 1], 64'd42);
        check("abort_no_pulse", 64'(rise_cyc_q.size()), 64'(nr + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
